// File: rtl/hd44780_seq_reader_if.sv
// hd44780_seq_reader_if
//   Byte channel between the sequence reader and the HD44780 byte/nybble driver.
//   A byte moves on a cycle where byte_valid and byte_ready are both high.
//   Signals:
//     byte_valid  reader -> driver  byte offer
//     byte_ready  driver -> reader  driver can take the offered byte
//     rs          reader -> driver  HD44780 RS for the byte (0 = command, 1 = data)
//     lcd_byte    reader -> driver  byte value
//   Modports: master = reader side, slave = driver side.
interface hd44780_seq_reader_if;
  logic       byte_valid;
  logic       byte_ready;
  logic       rs;
  logic [7:0] lcd_byte;

  modport master (output byte_valid, output rs, output lcd_byte, input byte_ready);
  modport slave  (input byte_valid, input rs, input lcd_byte, output byte_ready);
endinterface

// File: rtl/hd44780_seq_reader.sv
// hd44780_seq_reader
//   Walks hd44780_ram from a start address and executes 16-bit instruction words:
//     op = w[15:14]: 00 SEND byte (rs = w[8], byte = w[7:0]), 01 DELAY w[13:0] units,
//                    10 STOP, 11 JUMP to w[addr_width-1:0].
//   SEND words are offered to the LCD driver on the lcd interface; delays are timed
//   here in units of tick_clks clock cycles.
//   Ports:
//     clk         system clock (also clocks the RAM read port)
//     rst         synchronous active-high reset
//     start       1-cycle pulse, begins execution at start_addr (ignored while busy)
//     start_addr  first word address
//     raddr       RAM read address
//     rdata       RAM read data, valid one cycle after raddr is sampled
//     lcd         byte channel to the driver (master side)
//     busy        high in every state except IDLE
//     done        1-cycle pulse when a STOP word retires
module hd44780_seq_reader #(
  parameter int addr_width = 8,
  parameter int data_width = 16,
  parameter int tick_clks  = 48
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  start,
  input  logic [addr_width-1:0] start_addr,
  output logic [addr_width-1:0] raddr,
  input  logic [data_width-1:0] rdata,
  hd44780_seq_reader_if.master  lcd,
  output logic                  busy,
  output logic                  done
);

  localparam int tick_w = (tick_clks > 1) ? $clog2(tick_clks) : 1;
  localparam logic [tick_w-1:0] tick_last = tick_w'(tick_clks - 1);

  typedef enum logic [2:0] {
    IDLE, FETCH, WAIT, DECODE, SEND, DELAY, DONE
  } state_t;

  typedef enum logic [1:0] {
    OP_SEND  = 2'b00,
    OP_DELAY = 2'b01,
    OP_STOP  = 2'b10,
    OP_JUMP  = 2'b11
  } op_t;

  state_t            state;
  logic [13:0]       unit_count;
  logic [tick_w-1:0] tick;
  op_t               op;

  assign op = op_t'(rdata[15:14]);

  // Sequencer. The RAM read is registered, so a word is only usable in DECODE,
  // two cycles after the address was presented in FETCH. Address increments wrap
  // naturally at 2^addr_width.
  always_ff @(posedge clk) begin
    if (rst) begin
      state          <= IDLE;
      raddr          <= '0;
      busy           <= 1'b0;
      done           <= 1'b0;
      lcd.byte_valid <= 1'b0;
      lcd.rs         <= 1'b0;
      lcd.lcd_byte   <= 8'h00;
      unit_count     <= '0;
      tick           <= '0;
    end else begin
      done <= 1'b0;
      case (state)
        IDLE: begin
          if (start) begin
            raddr <= start_addr;
            busy  <= 1'b1;
            state <= FETCH;
          end
        end
        FETCH:  state <= WAIT;
        WAIT:   state <= DECODE;
        DECODE: begin
          case (op)
            OP_SEND: begin
              lcd.rs         <= rdata[8];
              lcd.lcd_byte   <= rdata[7:0];
              lcd.byte_valid <= 1'b1;
              state          <= SEND;
            end
            OP_DELAY: begin
              if (rdata[13:0] == 14'd0) begin
                raddr <= raddr + addr_width'(1);
                state <= FETCH;
              end else begin
                unit_count <= rdata[13:0];
                tick       <= '0;
                state      <= DELAY;
              end
            end
            OP_STOP: begin
              // done is raised on entry so it is high for exactly the DONE cycle
              done  <= 1'b1;
              state <= DONE;
            end
            OP_JUMP: begin
              raddr <= rdata[addr_width-1:0];
              state <= FETCH;
            end
            default: state <= IDLE;
          endcase
        end
        SEND: begin
          if (lcd.byte_ready) begin
            lcd.byte_valid <= 1'b0;
            raddr          <= raddr + addr_width'(1);
            state          <= FETCH;
          end
        end
        DELAY: begin
          // Leaving on the wrap that would take the unit count to zero keeps the
          // time spent in DELAY at exactly count * tick_clks cycles.
          if (tick == tick_last) begin
            tick <= '0;
            if (unit_count == 14'd1) begin
              unit_count <= '0;
              raddr      <= raddr + addr_width'(1);
              state      <= FETCH;
            end else begin
              unit_count <= unit_count - 14'd1;
            end
          end else begin
            tick <= tick + tick_w'(1);
          end
        end
        DONE: begin
          busy  <= 1'b0;
          state <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule
